btn_mode_controller: RTL and testbench

- Parametrised button front-end and mode controller for the timer/stopwatch designs.
- Generates the system tick from the fast clock, synchronises and debounces five push-buttons, and detects short and long presses with auto-repeat.
- Keeps independent run and direction state for each of NUM_MODES modes. Emits per-mode clear and load strobes to the downstream counter blocks.

---
 rtl/btn_mode_controller.sv | 174 +++++++++++++++++
 tb/tb_btn_mode_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/btn_mode_controller.sv
// Button front-end and mode controller: tick divider, per-button sync/debounce/hold
// channels, and registered per-mode run/dir/clr/ld actions.

module btn_chan #(
  parameter int DEBOUNCE_TICKS  = 2,
  parameter int LONGPRESS_TICKS = 100,
  parameter int REPEAT_TICKS    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic press,
  output logic rel,
  output logic lng,
  output logic rpt,
  output logic long_seen
);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(LONGPRESS_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  logic [1:0]    sync;
  logic          armed, stable, stable_q, long_done;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold;
  logic [RW-1:0] rcnt;

  // A button still held through reset stays locked out until it is seen low on a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      armed    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync     <= {sync[0], raw};
      stable_q <= stable;
      if (tick) begin
        if (!armed) begin
          armed <= ~sync[1];
        end else if (sync[1] != stable) begin
          if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
            stable <= ~stable;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end else begin
          db_cnt <= '0;
        end
      end
    end
  end

  assign press     = stable & ~stable_q;
  assign rel       = ~stable & stable_q;
  assign lng       = tick & stable & ~long_done & (hold == HW'(LONGPRESS_TICKS - 1));
  assign rpt       = tick & stable & long_done & (rcnt == RW'(REPEAT_TICKS - 1));
  assign long_seen = long_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      rcnt      <= '0;
      long_done <= 1'b0;
    end else if (press) begin
      hold      <= '0;
      rcnt      <= '0;
      long_done <= 1'b0;
    end else if (tick && stable) begin
      if (hold != HW'(LONGPRESS_TICKS)) hold <= hold + 1'b1;
      if (lng) begin
        long_done <= 1'b1;
        rcnt      <= '0;
      end else if (long_done) begin
        rcnt <= rpt ? '0 : rcnt + 1'b1;
      end
    end
  end
endmodule

module btn_mode_controller #(
  parameter int CLK_DIV         = 1_000_000,
  parameter int NUM_MODES       = 3,
  parameter int DEBOUNCE_TICKS  = 2,
  parameter int LONGPRESS_TICKS = 100,
  parameter int REPEAT_TICKS    = 10,
  parameter int MODE_W          = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btnu,
  input  logic                 btnd,
  input  logic                 btnc,
  input  logic                 btnl,
  input  logic                 btnr,
  output logic                 tick,
  output logic [MODE_W-1:0]    mode,
  output logic [NUM_MODES-1:0] run,
  output logic [NUM_MODES-1:0] dir,
  output logic [NUM_MODES-1:0] clr,
  output logic [NUM_MODES-1:0] ld
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int NB = 5;
  localparam int BU = 0, BD = 1, BC = 2, BL = 3, BR = 4;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == CW'(CLK_DIV - 1));
      div_cnt <= (div_cnt == CW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end
  end

  logic [NB-1:0] raw, press, rel, lng, rpt, lseen;
  assign raw = {btnr, btnl, btnc, btnd, btnu};

  for (genvar i = 0; i < NB; i++) begin : g_btn
    btn_chan #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONGPRESS_TICKS(LONGPRESS_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .raw      (raw[i]),
      .press    (press[i]),
      .rel      (rel[i]),
      .lng      (lng[i]),
      .rpt      (rpt[i]),
      .long_seen(lseen[i])
    );
  end

  logic unused_evt;
  assign unused_evt = ^{press[BC], rel[BU], rel[BD], rel[BL], rel[BR],
                        lng[BU], lng[BD], lng[BL], rpt[BU], rpt[BD], rpt[BC], rpt[BL],
                        lseen[BU], lseen[BD], lseen[BL], lseen[BR]};

  logic [NUM_MODES-1:0] sel;
  assign sel = NUM_MODES'(1) << mode;

  // All actions use the mode as it was before this cycle's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= '0;
      run  <= '0;
      dir  <= '0;
      clr  <= '0;
      ld   <= '0;
    end else begin
      clr <= press[BD] ? sel : '0;
      ld  <= (press[BR] | lng[BR] | rpt[BR]) ? sel : '0;
      if (lng[BC])
        mode <= '0;
      else if (rel[BC] && !lseen[BC])
        mode <= (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + 1'b1;
      if (press[BD])
        run <= run & ~sel;
      else if (press[BU])
        run <= run ^ sel;
      if (press[BL])
        dir <= dir ^ sel;
    end
  end
endmodule

// File: tb/tb_btn_mode_controller.sv
// Directed bench for btn_mode_controller with CLK_DIV=4, 3 modes, debounce 2, long 8, repeat 3.

module tb_btn_mode_controller;
  logic       clk = 1'b0, rst = 1'b1;
  logic       btnu = 0, btnd = 0, btnc = 0, btnl = 0, btnr = 0;
  logic       tick;
  logic [1:0] mode;
  logic [2:0] run, dir, clr, ld;
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0;

  btn_mode_controller #(
    .CLK_DIV(4), .NUM_MODES(3), .DEBOUNCE_TICKS(2), .LONGPRESS_TICKS(8), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .btnu(btnu), .btnd(btnd), .btnc(btnc), .btnl(btnl), .btnr(btnr),
    .tick(tick), .mode(mode), .run(run), .dir(dir), .clr(clr), .ld(ld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Land on a negedge two cycles after a tick edge so latencies are fixed.
  task automatic align();
    @(negedge clk);
    while (cyc % 4 != 2) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic short_c(input logic [1:0] m0, input logic [1:0] m1);
    int p;
    align(); p = cyc; btnc = 1;
    wait_until(p + 9);  chk("c_press_no_change", mode, m0);
    wait_until(p + 16); btnc = 0;
    wait_until(p + 23); chk("c_before_release", mode, m0);
    wait_until(p + 24); chk("c_after_release", mode, m1);
    step(8);
  endtask

  task automatic press_u(input logic [2:0] r0, input logic [2:0] r1);
    int p;
    align(); p = cyc; btnu = 1;
    wait_until(p + 7);  chk("u_before", run, r0);
    wait_until(p + 8);  chk("u_after", run, r1);
    wait_until(p + 20); btnu = 0;
    wait_until(p + 40); chk("u_once", run, r1);
  endtask

  initial begin
    int p, cnt;
    int offs [8];
    int exp_offs [5];
    logic [2:0] acc;
    exp_offs = '{8, 39, 51, 63, 75};

    // 1: reset and idle
    step(3);
    chk("reset_outs", {tick, mode, run, dir, clr, ld}, 0);
    rst = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      chk("tick", tick, (i % 4 == 0));
      chk("idle_outs", {mode, run, dir, clr, ld}, 0);
    end

    // 2: glitch ignored, then two debounced presses
    align(); p = cyc; btnu = 1;
    wait_until(p + 4); btnu = 0;
    step(16); chk("u_glitch", run, 3'b000);
    press_u(3'b000, 3'b001);
    press_u(3'b001, 3'b000);

    // 3: short centre presses advance on release
    short_c(2'd0, 2'd1);
    short_c(2'd1, 2'd2);
    short_c(2'd2, 2'd0);

    // 4: long centre press from mode 2
    short_c(2'd0, 2'd1);
    short_c(2'd1, 2'd2);
    align(); p = cyc; btnc = 1;
    wait_until(p + 38); chk("c_long_before", mode, 2'd2);
    wait_until(p + 39); chk("c_long_at", mode, 2'd0);
    wait_until(p + 48); btnc = 0;
    wait_until(p + 64); chk("c_long_release_ignored", mode, 2'd0);

    // 5: load with long press and auto-repeat in mode 1
    short_c(2'd0, 2'd1);
    align(); p = cyc; btnr = 1; cnt = 0; acc = '0;
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (cyc == p + 76) btnr = 0;
      acc |= clr;
      if (ld != 3'b000) begin
        chk("ld_value", ld, 3'b010);
        if (cnt < 8) offs[cnt] = cyc - p;
        cnt++;
      end
    end
    chk("ld_count", cnt, 5);
    chk("r_clr_quiet", acc, 3'b000);
    for (int k = 0; k < 5; k++) chk("ld_offset", offs[k], exp_offs[k]);

    // 6: clear beats run toggle, then reset mid-press locks out btnl
    short_c(2'd1, 2'd2);
    press_u(3'b000, 3'b100);
    align(); p = cyc; btnu = 1; btnd = 1;
    wait_until(p + 7); chk("ud_clr_before", clr, 3'b000); chk("ud_run_before", run, 3'b100);
    wait_until(p + 8); chk("ud_clr", clr, 3'b100);        chk("ud_run", run, 3'b000);
    wait_until(p + 9); chk("ud_clr_single", clr, 3'b000); chk("ud_run_hold", run, 3'b000);
    wait_until(p + 20); btnu = 0; btnd = 0;
    step(16);

    align(); p = cyc; btnl = 1;
    wait_until(p + 8); chk("l_dir_mode2", dir, 3'b100);
    wait_until(p + 12); rst = 1;
    step(2);
    chk("rst_mid_outs", {tick, mode, run, dir, clr, ld}, 0);
    rst = 0; acc = '0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      acc |= dir;
    end
    chk("l_locked", acc, 3'b000);
    btnl = 0;
    step(20); chk("l_after_release", dir, 3'b000);
    align(); p = cyc; btnl = 1;
    wait_until(p + 7); chk("l_repress_before", dir, 3'b000);
    wait_until(p + 8); chk("l_repress", dir, 3'b001);
    wait_until(p + 20); btnl = 0;
    step(16);
    chk("final_mode", mode, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
